// File: rtl/branch_pred_pkg.sv
// Shared constants for the branch prediction unit.
// Mode selectors and performance counter helpers.
package branch_pred_pkg;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;
    localparam int PERF_WIDTH   = 16;

    function automatic logic [PERF_WIDTH-1:0] perf_inc(
        input logic [PERF_WIDTH-1:0] v
    );
        return (&v) ? v : v + PERF_WIDTH'(1);
    endfunction

endpackage

// File: rtl/bpu_sat_counter.sv
// Saturating up/down counter next-state logic.
// Counts toward taken (up) or not-taken (down), clamped at both ends.
module bpu_sat_counter
    import branch_pred_pkg::*;
#(
    parameter int CTR_WIDTH = 2
) (
    input  logic [CTR_WIDTH-1:0] cur,
    input  logic                 taken,
    output logic [CTR_WIDTH-1:0] next
);

    always_comb begin
        next = cur;
        if (taken) begin
            if (!(&cur))
                next = cur + CTR_WIDTH'(1);
        end else if (|cur) begin
            next = cur - CTR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/branch_prediction_unit_r1.sv
// Bimodal/gshare branch predictor with a global history register,
// checkpointed history for mispredict repair, and perf counters.
module branch_prediction_unit_r1
    import branch_pred_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int CTR_WIDTH  = 2,
    parameter int HIST_WIDTH = 6,
    parameter int MODE       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  predictValid,
    input  logic [ADDR_WIDTH-1:0] predictAddr,
    output logic                  prediction,
    output logic [ADDR_WIDTH-1:0] predictIndex,
    output logic [HIST_WIDTH-1:0] predictHist,
    input  logic                  update,
    input  logic [ADDR_WIDTH-1:0] updateIndex,
    input  logic [HIST_WIDTH-1:0] updateHist,
    input  logic                  branchTaken,
    input  logic                  mispredict,
    output logic [15:0]           updateCount,
    output logic [15:0]           mispredictCount
);

    localparam int ENTRIES = 1 << ADDR_WIDTH;

    logic [CTR_WIDTH-1:0]  pht_q [ENTRIES];
    logic [CTR_WIDTH-1:0]  upd_next;
    logic [HIST_WIDTH-1:0] ghr_q;
    logic [HIST_WIDTH-1:0] ghr_shift;
    logic [HIST_WIDTH-1:0] ghr_repair;
    logic [PERF_WIDTH-1:0] upd_cnt_q;
    logic [PERF_WIDTH-1:0] mis_cnt_q;

    generate
        if (MODE == MODE_GSHARE) begin : g_gshare
            assign predictIndex = predictAddr ^ ADDR_WIDTH'(ghr_q);
        end else begin : g_bimodal
            assign predictIndex = predictAddr;
        end
    endgenerate

    // Repair value rebuilds history as if the resolved branch had been
    // shifted into the checkpoint taken at prediction time.
    generate
        if (HIST_WIDTH == 1) begin : g_h1
            assign ghr_shift  = prediction;
            assign ghr_repair = branchTaken;
        end else begin : g_hn
            logic unused_hist_msb;
            assign unused_hist_msb = updateHist[HIST_WIDTH-1];
            assign ghr_shift  = {ghr_q[HIST_WIDTH-2:0], prediction};
            assign ghr_repair = {updateHist[HIST_WIDTH-2:0], branchTaken};
        end
    endgenerate

    assign prediction      = pht_q[predictIndex][CTR_WIDTH-1];
    assign predictHist     = ghr_q;
    assign updateCount     = upd_cnt_q;
    assign mispredictCount = mis_cnt_q;

    bpu_sat_counter #(
        .CTR_WIDTH(CTR_WIDTH)
    ) u_sat (
        .cur   (pht_q[updateIndex]),
        .taken (branchTaken),
        .next  (upd_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                pht_q[i] <= '0;
            ghr_q     <= '0;
            upd_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (update) begin
                pht_q[updateIndex] <= upd_next;
                upd_cnt_q          <= perf_inc(upd_cnt_q);
                if (mispredict)
                    mis_cnt_q <= perf_inc(mis_cnt_q);
            end
            if (update && mispredict)
                ghr_q <= ghr_repair;
            else if (predictValid)
                ghr_q <= ghr_shift;
        end
    end

endmodule

// File: tb/tb_branch_prediction_unit_r1.sv
// Bench for branch_prediction_unit_r1: directed vector table, random
// traffic against a reference model, counter saturation and reset.
module tb_branch_prediction_unit_r1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pv = 1'b0;
    logic [5:0] addr = '0;
    logic       upd = 1'b0;
    logic [5:0] uidx = '0;
    logic [5:0] uhist = '0;
    logic       tk = 1'b0;
    logic       mis = 1'b0;

    logic        pred_g, pred_b;
    logic [5:0]  idx_g, idx_b, hist_g, hist_b;
    logic [15:0] uc_g, uc_b, mc_g, mc_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    branch_prediction_unit_r1 #(
        .ADDR_WIDTH(6), .CTR_WIDTH(2), .HIST_WIDTH(6), .MODE(1)
    ) u_gs (
        .clk(clk), .rst(rst),
        .predictValid(pv), .predictAddr(addr),
        .prediction(pred_g), .predictIndex(idx_g), .predictHist(hist_g),
        .update(upd), .updateIndex(uidx), .updateHist(uhist),
        .branchTaken(tk), .mispredict(mis),
        .updateCount(uc_g), .mispredictCount(mc_g)
    );

    branch_prediction_unit_r1 #(
        .ADDR_WIDTH(6), .CTR_WIDTH(2), .HIST_WIDTH(6), .MODE(0)
    ) u_bm (
        .clk(clk), .rst(rst),
        .predictValid(pv), .predictAddr(addr),
        .prediction(pred_b), .predictIndex(idx_b), .predictHist(hist_b),
        .update(upd), .updateIndex(uidx), .updateHist(uhist),
        .branchTaken(tk), .mispredict(mis),
        .updateCount(uc_b), .mispredictCount(mc_b)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h @%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       pv;
        logic [5:0] addr;
        logic       upd;
        logic [5:0] uidx;
        logic [5:0] uhist;
        logic       tk;
        logic       mis;
        logic       ep;
        logic [5:0] eidx;
        logic [5:0] ehist;
    } vec_t;

    vec_t vt[18];

    // reference model state
    int tbl[64];
    int gh_g, gh_b, ucnt, mcnt;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) tbl[i] = 0;
        gh_g = 0; gh_b = 0; ucnt = 0; mcnt = 0;
    endtask

    initial begin
        vt[0]  = '{0, 6'h05, 1, 6'h05, 6'h00, 1, 0, 0, 6'h05, 6'h00};
        vt[1]  = '{0, 6'h05, 1, 6'h05, 6'h00, 1, 0, 0, 6'h05, 6'h00};
        vt[2]  = '{0, 6'h05, 1, 6'h05, 6'h00, 1, 0, 1, 6'h05, 6'h00};
        vt[3]  = '{0, 6'h05, 1, 6'h05, 6'h00, 1, 0, 1, 6'h05, 6'h00};
        vt[4]  = '{0, 6'h05, 0, 6'h00, 6'h00, 0, 0, 1, 6'h05, 6'h00};
        vt[5]  = '{0, 6'h05, 1, 6'h05, 6'h00, 0, 0, 1, 6'h05, 6'h00};
        vt[6]  = '{0, 6'h05, 1, 6'h05, 6'h00, 0, 0, 1, 6'h05, 6'h00};
        vt[7]  = '{0, 6'h05, 0, 6'h00, 6'h00, 0, 0, 0, 6'h05, 6'h00};
        vt[8]  = '{0, 6'h00, 1, 6'h09, 6'h01, 1, 1, 0, 6'h00, 6'h00};
        vt[9]  = '{1, 6'h0C, 0, 6'h00, 6'h00, 0, 0, 0, 6'h0F, 6'h03};
        vt[10] = '{0, 6'h0C, 0, 6'h00, 6'h00, 0, 0, 0, 6'h0A, 6'h06};
        vt[11] = '{1, 6'h00, 1, 6'h03, 6'h2A, 1, 1, 0, 6'h06, 6'h06};
        vt[12] = '{0, 6'h17, 0, 6'h00, 6'h00, 0, 0, 0, 6'h02, 6'h15};
        vt[13] = '{0, 6'h17, 1, 6'h02, 6'h00, 1, 0, 0, 6'h02, 6'h15};
        vt[14] = '{0, 6'h17, 1, 6'h02, 6'h00, 1, 0, 0, 6'h02, 6'h15};
        vt[15] = '{0, 6'h17, 0, 6'h00, 6'h00, 0, 0, 1, 6'h02, 6'h15};
        vt[16] = '{0, 6'h17, 0, 6'h02, 6'h3F, 0, 1, 1, 6'h02, 6'h15};
        vt[17] = '{0, 6'h17, 0, 6'h00, 6'h00, 0, 0, 1, 6'h02, 6'h15};

        // reset state
        #2;
        chk("rst_pred", 32'(pred_g), 0);
        chk("rst_hist", 32'(hist_g), 0);
        chk("rst_ucnt", 32'(uc_g), 0);
        chk("rst_mcnt", 32'(mc_g), 0);
        @(negedge clk);
        rst = 1'b0;
        addr = 6'h2B;
        #1;
        chk("rst_pred_any", 32'(pred_g), 0);

        // directed vector table
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            pv = vt[i].pv; addr = vt[i].addr; upd = vt[i].upd;
            uidx = vt[i].uidx; uhist = vt[i].uhist;
            tk = vt[i].tk; mis = vt[i].mis;
            #1;
            chk($sformatf("vec%0d_pred", i), 32'(pred_g), 32'(vt[i].ep));
            chk($sformatf("vec%0d_idx", i), 32'(idx_g), 32'(vt[i].eidx));
            chk($sformatf("vec%0d_hist", i), 32'(hist_g), 32'(vt[i].ehist));
        end
        @(negedge clk);
        pv = 0; upd = 0; mis = 0;
        #1;
        chk("vec_ucnt", 32'(uc_g), 10);
        chk("vec_mcnt", 32'(mc_g), 2);

        // random traffic vs. model, both modes
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            int ig, ib, pg, pb, t;
            @(negedge clk);
            pv = 1'($urandom);
            addr = 6'($urandom);
            upd = ($urandom_range(0, 2) != 0);
            uidx = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7))
                                              : 6'($urandom);
            uhist = 6'($urandom);
            tk = 1'($urandom);
            mis = ($urandom_range(0, 3) == 0);
            ig = int'(addr) ^ gh_g;
            ib = int'(addr);
            pg = (tbl[ig] >= 2) ? 1 : 0;
            pb = (tbl[ib] >= 2) ? 1 : 0;
            #1;
            chk("rnd_gs_pred", 32'(pred_g), 32'(pg));
            chk("rnd_gs_idx", 32'(idx_g), 32'(ig));
            chk("rnd_gs_hist", 32'(hist_g), 32'(gh_g));
            chk("rnd_bm_pred", 32'(pred_b), 32'(pb));
            chk("rnd_bm_idx", 32'(idx_b), 32'(ib));
            chk("rnd_bm_hist", 32'(hist_b), 32'(gh_b));
            chk("rnd_ucnt", 32'(uc_g), 32'(ucnt));
            chk("rnd_mcnt", 32'(mc_b), 32'(mcnt));
            if (upd) begin
                t = int'(uidx);
                tbl[t] = tk ? ((tbl[t] < 3) ? tbl[t] + 1 : 3)
                            : ((tbl[t] > 0) ? tbl[t] - 1 : 0);
                ucnt = (ucnt < 65535) ? ucnt + 1 : 65535;
                if (mis) mcnt = (mcnt < 65535) ? mcnt + 1 : 65535;
            end
            if (upd && mis) begin
                gh_g = (int'(uhist) * 2 + int'(tk)) % 64;
                gh_b = gh_g;
            end else if (pv) begin
                gh_g = (gh_g * 2 + pg) % 64;
                gh_b = (gh_b * 2 + pb) % 64;
            end
        end

        // counter saturation
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        pv = 0; upd = 1; mis = 1; tk = 1; uidx = 6'h11; uhist = '0;
        repeat (65540) @(posedge clk);
        @(negedge clk);
        chk("sat_ucnt", 32'(uc_g), 32'hFFFF);
        chk("sat_mcnt", 32'(mc_g), 32'hFFFF);
        chk("sat_ucnt_bm", 32'(uc_b), 32'hFFFF);

        // async reset with no clock edge, then an edge held in reset
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ucnt", 32'(uc_g), 0);
        chk("arst_mcnt", 32'(mc_g), 0);
        addr = 6'h11;
        #1;
        chk("arst_pred", 32'(pred_b), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("held_ucnt", 32'(uc_g), 0);
        chk("held_hist", 32'(hist_g), 0);
        @(posedge clk);
        @(negedge clk);
        chk("post_ucnt", 32'(uc_g), 1);
        chk("post_mcnt", 32'(mc_g), 1);
        chk("post_hist", 32'(hist_g), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
